// File: rtl/cardinal_nic.sv
// Single-slot processor/router network interface: one input buffer and one output buffer, each with a full flag.
// Optional sticky overflow status bit: define NIC_OVERFLOW_FLAG_EN.
module cardinal_nic (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic [63:0] d_in,
    output logic [63:0] d_out,
    input  logic        nicEn,
    input  logic        nicWrEn,
    input  logic        net_si,
    output logic        net_ri,
    input  logic [63:0] net_di,
    output logic        net_so,
    input  logic        net_ro,
    output logic [63:0] net_do,
    input  logic        net_polarity
);

    logic [63:0] ib_q, ib_d;
    logic [63:0] ob_q, ob_d;
    logic        ib_full_q, ib_full_d;
    logic        ob_full_q, ob_full_d;
    logic        rd_en, wr_en;
    logic        ovf;

    assign rd_en  = nicEn & ~nicWrEn;
    assign wr_en  = nicEn & nicWrEn;
    assign net_ri = ~ib_full_q;
    assign net_do = ob_q;
    // Bit 63 of the packet selects the virtual channel; it may only go out on the opposite polarity.
    assign net_so = ob_full_q & net_ro & (net_polarity != ob_q[63]);

    always_comb begin
        d_out = 64'd0;
        if (rd_en) begin
            case (addr)
                2'b00:   d_out = ib_q;
                2'b01:   d_out = {63'd0, ib_full_q};
                2'b10:   d_out = 64'd0;
                default: d_out = {62'd0, ovf, ob_full_q};
            endcase
        end
    end

    always_comb begin
        ib_d      = ib_q;
        ib_full_d = ib_full_q;
        ob_d      = ob_q;
        ob_full_d = ob_full_q;
        if (net_si && !ib_full_q) begin
            ib_d      = net_di;
            ib_full_d = 1'b1;
        end else if (rd_en && (addr == 2'b00) && ib_full_q) begin
            ib_full_d = 1'b0;
        end
        // Injection and a successful write are exclusive: both depend on ob_full_q.
        if (net_so) begin
            ob_full_d = 1'b0;
        end else if (wr_en && (addr == 2'b10) && !ob_full_q) begin
            ob_d      = d_in;
            ob_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ib_q      <= 64'd0;
            ob_q      <= 64'd0;
            ib_full_q <= 1'b0;
            ob_full_q <= 1'b0;
        end else begin
            ib_q      <= ib_d;
            ob_q      <= ob_d;
            ib_full_q <= ib_full_d;
            ob_full_q <= ob_full_d;
        end
    end

`ifdef NIC_OVERFLOW_FLAG_EN
    logic ovf_q, ovf_d;
    logic wr_drop;

    assign wr_drop = wr_en & (addr == 2'b10) & ob_full_q;

    // A drop in the same cycle as a status read wins, so no overflow is ever lost.
    always_comb begin
        ovf_d = ovf_q;
        if (rd_en && (addr == 2'b11)) ovf_d = 1'b0;
        if (wr_drop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: doc/cardinal_nic.md
CARDINAL_NIC -- requirements
Module: cardinal_nic

Interface
REQ-001 The block SHALL have exactly one clock and one reset, listed first in the port order below.
REQ-002 clk  input  1  Single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  Synchronous, active-low reset.
REQ-004 addr  input  2  Processor register select: 00 input buffer, 01 input status, 10 output buffer, 11 output status.
REQ-005 d_in  input  64  Processor write data.
REQ-006 d_out  output  64  Processor read data.
REQ-007 nicEn  input  1  Processor access enable.
REQ-008 nicWrEn  input  1  Access type: 1 = write, 0 = read; valid only with nicEn=1.
REQ-009 net_si  input  1  Router send-in; packet on net_di is valid.
REQ-010 net_ri  output  1  NIC ready to accept a packet from the router.
REQ-011 net_di  input  64  Packet from the router to the PE.
REQ-012 net_so  output  1  NIC send-out; packet on net_do is valid.
REQ-013 net_ro  input  1  Router ready to accept an injected packet.
REQ-014 net_do  output  64  Packet from the NIC to the router.
REQ-015 net_polarity  input  1  Router cycle polarity; 0 = even, 1 = odd; toggles every cycle.

Function
REQ-016 The block SHALL hold one 64-bit input buffer with a full flag (ib_full) and one 64-bit output buffer with a full flag (ob_full).
REQ-017 net_ri SHALL equal !ib_full, combinationally.
REQ-018 On a posedge with net_si=1 and net_ri=1, net_di SHALL be captured into the input buffer and ib_full SHALL be set; net_si=1 with net_ri=0 SHALL be ignored.
REQ-019 A processor read (nicEn=1, nicWrEn=0) SHALL drive d_out combinationally: addr 00 returns the input buffer; addr 01 returns {63'b0, ib_full}; addr 10 returns 0; addr 11 returns {62'b0, ovf, ob_full}.
REQ-020 With no read in progress, d_out SHALL be 0.
REQ-021 A read of addr 00 with ib_full=1 SHALL clear ib_full at that posedge, so net_ri rises in the next cycle.
REQ-022 A read of addr 00 with ib_full=0 SHALL return stale data and change no state.
REQ-023 A write (nicEn=1, nicWrEn=1, addr 10) with ob_full=0 SHALL load d_in into the output buffer and set ob_full at that posedge.
REQ-024 A write to addr 10 with ob_full=1 SHALL be dropped, leaving the buffer unchanged.
REQ-025 Writes to addr 00, 01 and 11 SHALL have no effect.
REQ-026 net_so SHALL be 1 only when ob_full=1, net_ro=1, and net_polarity != net_do[63]; the injection then completes at the next posedge.
REQ-027 net_do SHALL always present the output buffer contents.
REQ-028 At a completing injection posedge, ob_full SHALL clear.
REQ-029 A processor write arriving in the same cycle as the completing injection SHALL be dropped, because ob_full is still 1 in that cycle.
REQ-030 The earliest injection SHALL occur in the cycle after the write; it then waits for the first cycle that meets REQ-026.
REQ-031 The block SHALL contain no combinational path from net_si to net_ri, or from net_ro to net_do.

Reset
REQ-032 On a posedge with reset=0, ib_full, ob_full, both buffers and ovf SHALL be cleared.
REQ-033 Consequently net_so=0, net_ri=1, net_do=0, and d_out=0 when no read is in progress.
REQ-034 Reset SHALL override any concurrent capture, injection or processor write, and SHALL discard buffered packets mid-operation.

Configuration
REQ-035 Macro NIC_OVERFLOW_FLAG_EN defined: ovf SHALL be a sticky bit set by any write dropped under REQ-024 or REQ-029.
REQ-036 With NIC_OVERFLOW_FLAG_EN defined: ovf SHALL clear on a read of addr 11, the read returning the pre-clear value; a set and a clear in the same cycle SHALL leave ovf set.
REQ-037 Macro NIC_OVERFLOW_FLAG_EN not defined: ovf SHALL be constant 0 and no ovf register SHALL be synthesized.

Verification
REQ-038 Reset then idle -> net_ri=1, net_so=0, status reads of addr 01 and 11 return 0.
REQ-039 Router sends 64'h0000_0001_0000_0002 with net_si=1 -> net_ri=0 next cycle; addr 00 read returns that packet; net_ri=1 the cycle after the read.
REQ-040 Write 64'h8000_0000_0000_0003 (vc=1) with net_ro=1 -> net_so asserted only in cycles with net_polarity=0; ob_full=0 after the handshake.
REQ-041 Hold net_ro=0 and write twice -> second write dropped, net_do keeps the first value, addr 11 reads 2'b11 (ovf set) with the macro and 2'b01 without; a second addr 11 read returns 2'b01.
REQ-042 Second packet on net_si while ib_full=1 -> not captured; buffer keeps the first packet.
REQ-043 Assert reset=0 while ob_full=1 and ib_full=1 -> next cycle net_so=0, net_ri=1, all status bits 0.
